// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush and
// an optional 2-entry skid buffer.
//
// Parameters:
//   DATA_W  payload width in bits
//   SKID    1: 2-entry skid buffer, in_ready_o depends on state only
//           0: single entry, in_ready_o also follows out_ready_i combinationally
//   BUBBLE  value presented on out_data_o whenever the stage is empty
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       synchronous reset, active low
//   en_i         stage enable; low freezes state and blocks both handshakes
//   flush_i      discard held and incoming payload this cycle
//   in_valid_i   upstream has payload
//   in_ready_o   stage accepts payload this cycle
//   in_data_i    upstream payload
//   out_valid_o  stage presents valid payload
//   out_ready_i  downstream accepts payload
//   out_data_o   presented payload (BUBBLE when empty)
//   occupancy_o  entries held: 0, 1 or 2
module pipe_stage_reg #(
  parameter int unsigned       DATA_W = 96,
  parameter bit                SKID   = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkidF = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  logic in_fire;
  logic out_fire;

  // Handshake outputs are gated by reset and enable so nothing transfers while
  // the stage is held in reset or frozen.
  always_comb begin
    if (SKID) begin
      in_ready_o = rst_ni & en_i & (state_q != StSkidF);
    end else begin
      in_ready_o = rst_ni & en_i & ((state_q == StEmpty) | out_ready_i);
    end
    out_valid_o = rst_ni & en_i & (state_q != StEmpty);
    out_data_o  = (!rst_ni || state_q == StEmpty) ? BUBBLE : main_q;
    unique case (state_q)
      StFull:  occupancy_o = rst_ni ? 2'd1 : 2'd0;
      StSkidF: occupancy_o = rst_ni ? 2'd2 : 2'd0;
      default: occupancy_o = 2'd0;
    endcase
  end

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Flush wins over en_i; any payload offered this cycle is dropped.
      state_d = StEmpty;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else if (en_i) begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StFull;
            main_d  = in_data_i;
          end
        end
        StFull: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire && SKID) begin
            // Downstream stalled: park the new payload behind the head.
            state_d = StSkidF;
            skid_d  = in_data_i;
          end else if (out_fire) begin
            state_d = StEmpty;
            main_d  = BUBBLE;
          end
        end
        StSkidF: begin
          if (out_fire) begin
            state_d = StFull;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int unsigned W   = 96;
  localparam logic [W-1:0] BUB = 96'h13;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT a: skid buffer enabled; DUT b: single entry.
  logic         a_en, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [W-1:0] a_in_data, a_out_data;
  logic [1:0]   a_occ;
  logic         b_en, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [W-1:0] b_in_data, b_out_data;
  logic [1:0]   b_occ;

  pipe_stage_reg #(.DATA_W(W), .SKID(1'b1), .BUBBLE(BUB)) u_skid (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (a_en),
    .flush_i     (a_flush),
    .in_valid_i  (a_in_valid),
    .in_ready_o  (a_in_ready),
    .in_data_i   (a_in_data),
    .out_valid_o (a_out_valid),
    .out_ready_i (a_out_ready),
    .out_data_o  (a_out_data),
    .occupancy_o (a_occ)
  );

  pipe_stage_reg #(.DATA_W(W), .SKID(1'b0), .BUBBLE(BUB)) u_noskid (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (b_en),
    .flush_i     (b_flush),
    .in_valid_i  (b_in_valid),
    .in_ready_o  (b_in_ready),
    .in_data_i   (b_in_data),
    .out_valid_o (b_out_valid),
    .out_ready_i (b_out_ready),
    .out_data_o  (b_out_data),
    .occupancy_o (b_occ)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven just after the falling edge; outputs settle 1 time unit later.
  task automatic settle();
    #1;
  endtask

  // Scoreboard bookkeeping for the coming rising edge, then advance one cycle.
  task automatic adv();
    if (a_out_valid && a_out_ready) begin
      if (qa.size() == 0) chk("a_spurious_out", {95'd0, a_out_valid}, '0);
      else chk("a_sb_data", a_out_data, qa.pop_front());
    end
    if (b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("b_spurious_out", {95'd0, b_out_valid}, '0);
      else chk("b_sb_data", b_out_data, qb.pop_front());
    end
    if (!rst_n || a_flush) qa.delete();
    else if (a_in_valid && a_in_ready && a_en) qa.push_back(a_in_data);
    if (!rst_n || b_flush) qb.delete();
    else if (b_in_valid && b_in_ready && b_en) qb.push_back(b_in_data);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 1'b1; a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 96'hA5; a_out_ready = 1'b1;
    b_en = 1'b1; b_flush = 1'b0; b_in_valid = 1'b1; b_in_data = 96'hA5; b_out_ready = 1'b1;
    @(negedge clk);

    // 1: reset held two cycles with payload offered
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("rst_in_ready", {95'd0, a_in_ready}, '0);
      chk("rst_out_valid", {95'd0, a_out_valid}, '0);
      chk("rst_out_data", a_out_data, BUB);
      chk("rst_occ", {94'd0, a_occ}, '0);
      chk("rst_b_in_ready", {95'd0, b_in_ready}, '0);
      adv();
    end
    rst_n = 1'b1; a_in_valid = 1'b0; b_in_valid = 1'b0;
    settle();
    chk("post_rst_occ", {94'd0, a_occ}, '0);
    chk("post_rst_data", a_out_data, BUB);
    adv();

    // 2: stream 1,2,3 with downstream always ready
    for (int i = 1; i <= 4; i++) begin
      a_in_valid = (i <= 3);
      a_in_data  = W'(i);
      settle();
      if (i == 1) chk("stream_ready", {95'd0, a_in_ready}, 96'd1);
      if (i >= 2) begin
        chk("stream_occ", {94'd0, a_occ}, 96'd1);
        chk("stream_data", a_out_data, W'(i - 1));
      end
      adv();
    end
    settle();
    chk("stream_drained_occ", {94'd0, a_occ}, '0);

    // 3: skid fill with downstream stalled, then drain
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 96'h10;
    settle(); adv();
    a_in_data = 96'h11;
    settle();
    chk("skid_ready_full", {95'd0, a_in_ready}, 96'd1);
    adv();
    a_in_valid = 1'b0;
    settle();
    chk("skid_occ2", {94'd0, a_occ}, 96'd2);
    chk("skid_not_ready", {95'd0, a_in_ready}, '0);
    chk("skid_head", a_out_data, 96'h10);
    adv();
    a_out_ready = 1'b1;
    settle();
    chk("drain_occ2", {94'd0, a_occ}, 96'd2);
    adv();
    settle();
    chk("drain_occ1", {94'd0, a_occ}, 96'd1);
    chk("drain_second", a_out_data, 96'h11);
    adv();
    settle();
    chk("drain_occ0", {94'd0, a_occ}, '0);
    chk("drain_valid0", {95'd0, a_out_valid}, '0);
    chk("drain_bubble", a_out_data, BUB);

    // 4: no-skid stage, combinational ready from out_ready
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 96'h20;
    settle(); adv();
    b_in_data = 96'h99;
    settle();
    chk("ns_stall_ready", {95'd0, b_in_ready}, '0);
    chk("ns_occ1", {94'd0, b_occ}, 96'd1);
    adv();
    b_out_ready = 1'b1; b_in_data = 96'h21;
    settle();
    chk("ns_ready_same_cycle", {95'd0, b_in_ready}, 96'd1);
    chk("ns_head", b_out_data, 96'h20);
    adv();
    b_in_valid = 1'b0;
    settle();
    chk("ns_reload", b_out_data, 96'h21);
    chk("ns_reload_valid", {95'd0, b_out_valid}, 96'd1);
    adv();
    settle();
    chk("ns_empty", {94'd0, b_occ}, '0);

    // 5: flush with two entries held and a payload offered
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 96'h30;
    settle(); adv();
    a_in_data = 96'h31;
    settle(); adv();
    a_flush = 1'b1; a_in_data = 96'h33;
    settle();
    chk("flush_pre_occ", {94'd0, a_occ}, 96'd2);
    adv();
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    settle();
    chk("flush_occ", {94'd0, a_occ}, '0);
    chk("flush_bubble", a_out_data, BUB);
    adv(); adv();
    // flush while ready: offered payload must still be dropped
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 96'h34;
    settle(); adv();
    a_flush = 1'b1; a_in_data = 96'h36;
    settle(); adv();
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    settle();
    chk("flush_drop_occ", {94'd0, a_occ}, '0);
    adv(); adv();

    // 6: enable low freezes a full stage
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 96'h44;
    settle(); adv();
    a_en = 1'b0; a_in_data = 96'h55; a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("en0_valid", {95'd0, a_out_valid}, '0);
      chk("en0_ready", {95'd0, a_in_ready}, '0);
      chk("en0_occ", {94'd0, a_occ}, 96'd1);
      adv();
    end
    a_en = 1'b1; a_in_valid = 1'b0;
    settle();
    chk("en1_valid", {95'd0, a_out_valid}, 96'd1);
    chk("en1_data", a_out_data, 96'h44);
    adv();
    settle();
    chk("en1_empty", {94'd0, a_occ}, '0);

    // Reset mid-stall discards skid contents
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 96'h60;
    settle(); adv();
    a_in_data = 96'h61;
    settle(); adv();
    rst_n = 1'b0; a_in_valid = 1'b0;
    settle(); adv();
    rst_n = 1'b1; a_out_ready = 1'b1;
    settle();
    chk("rst_stall_occ", {94'd0, a_occ}, '0);
    chk("rst_stall_data", a_out_data, BUB);
    adv(); adv(); adv();

    chk("a_sb_drained", W'(qa.size()), '0);
    chk("b_sb_drained", W'(qb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
